// File: rtl/bcd_seg_pkg.sv
// Shared types and constants for the BCD seven-segment scan driver:
// scan slot states, blank pattern, BCD limit and the active-high segment table.
package bcd_seg_pkg;

    typedef enum logic [1:0] {
        ONES   = 2'd0,
        BLANK0 = 2'd1,
        TENS   = 2'd2,
        BLANK1 = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // Index 0 sits in the least significant slot, so the list reads 9 down to 0.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, active-high, segment order {g,f,e,d,c,b,a}.
// Codes above 9 decode to all segments off.
module bcd_to_seg7
    import bcd_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= BCD_MAX) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/bcd_seg_scan_driver.sv
// Two-digit multiplexed seven-segment driver fed by an upstream decade counter.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens digit while it is zero.
module bcd_seg_scan_driver
    import bcd_seg_pkg::*;
#(
    parameter int SCAN_W         = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       x,
    input  logic       reset,
    input  logic [3:0] z_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] tens,
    output logic       wrap,
    output logic       carry,
    output logic       bcd_err
);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

    scan_state_t       state;
    scan_state_t       state_next;
    logic [SCAN_W-1:0] scan_cnt;
    logic [3:0]        ones_q;
    logic [3:0]        digit_sel;
    logic [6:0]        seg_raw;
    logic [6:0]        seg_hi_next;
    logic [1:0]        an_hi_next;
    logic              wrap_hit;

    assign wrap_hit  = (ones_q == BCD_MAX) && (z_in == 4'd0);
    assign digit_sel = (state == TENS) ? tens : ones_q;

    bcd_to_seg7 u_dec (
        .bcd (digit_sel),
        .seg (seg_raw)
    );

    always_ff @(posedge x) begin
        if (reset) begin
            state    <= ONES;
            scan_cnt <= '0;
        end else begin
            state    <= state_next;
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Slot advances only on the last cycle of the scan timer.
    always_comb begin
        state_next  = state;
        seg_hi_next = SEG_BLANK;
        an_hi_next  = 2'b00;
        if (&scan_cnt) begin
            case (state)
                ONES:    state_next = BLANK0;
                BLANK0:  state_next = TENS;
                TENS:    state_next = BLANK1;
                default: state_next = ONES;
            endcase
        end
        case (state)
            ONES: begin
                an_hi_next  = 2'b01;
                seg_hi_next = seg_raw;
            end
            TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (tens != 4'd0) begin
                    an_hi_next  = 2'b10;
                    seg_hi_next = seg_raw;
                end
`else
                an_hi_next  = 2'b10;
                seg_hi_next = seg_raw;
`endif
            end
            default: begin
                an_hi_next  = 2'b00;
                seg_hi_next = SEG_BLANK;
            end
        endcase
    end

    // Only a true 9->0 step of the upstream count advances tens; invalid codes hold it.
    always_ff @(posedge x) begin
        if (reset) begin
            ones_q  <= 4'd0;
            tens    <= 4'd0;
            wrap    <= 1'b0;
            carry   <= 1'b0;
            bcd_err <= 1'b0;
            seg     <= SEG_OFF;
            an      <= AN_OFF;
        end else begin
            ones_q  <= z_in;
            bcd_err <= (z_in > BCD_MAX);
            wrap    <= wrap_hit;
            carry   <= wrap_hit && (tens == BCD_MAX);
            if (wrap_hit) begin
                tens <= (tens == BCD_MAX) ? 4'd0 : tens + 4'd1;
            end
            seg <= SEG_ACTIVE_LOW ? ~seg_hi_next : seg_hi_next;
            an  <= SEG_ACTIVE_LOW ? ~an_hi_next  : an_hi_next;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan_driver.sv
// Directed bench for bcd_seg_scan_driver at default parameters (SCAN_W=4, active-low).
// Expected TENS-slot values follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_bcd_seg_scan_driver;

    logic       x;
    logic       reset;
    logic [3:0] z_in;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] tens;
    logic       wrap;
    logic       carry;
    logic       bcd_err;

    int tests_run;
    int tests_failed;

    bcd_seg_scan_driver dut (
        .x       (x),
        .reset   (reset),
        .z_in    (z_in),
        .seg     (seg),
        .an      (an),
        .tens    (tens),
        .wrap    (wrap),
        .carry   (carry),
        .bcd_err (bcd_err)
    );

    initial x = 1'b0;
    always #10 x = ~x;

    task automatic step();
        @(posedge x);
        #1;
    endtask

    task automatic run_decade();
        for (int k = 1; k <= 9; k++) begin
            z_in = k[3:0];
            step();
        end
        z_in = 4'd0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        z_in  = 4'd0;
        step();
        step();
        reset = 1'b0;
        tests_run++;
        if (seg !== 7'h7F || an !== 2'b11 || tens !== 4'd0 ||
            wrap !== 1'b0 || carry !== 1'b0 || bcd_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: seg=%h an=%b tens=%0d wrap=%b carry=%b err=%b, want seg=7f an=11 tens=0 wrap=0 carry=0 err=0",
                     seg, an, tens, wrap, carry, bcd_err);
        end
    endtask

    task automatic test_count_wrap();
        for (int k = 1; k <= 9; k++) begin
            z_in = k[3:0];
            step();
            tests_run++;
            if (wrap !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL no_wrap_%0d: wrap=%b want 0", k, wrap);
            end
        end
        z_in = 4'd0;
        step();
        tests_run++;
        if (wrap !== 1'b1 || tens !== 4'd1 || carry !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL first_wrap: wrap=%b tens=%0d carry=%b want wrap=1 tens=1 carry=0", wrap, tens, carry);
        end
        step();
        tests_run++;
        if (wrap !== 1'b0 || tens !== 4'd1) begin
            tests_failed++;
            $display("[TB] FAIL wrap_one_cycle: wrap=%b tens=%0d want wrap=0 tens=1", wrap, tens);
        end
    endtask

    task automatic test_hundreds_carry();
        logic [3:0] exp_tens;
        logic       exp_carry;
        exp_tens = 4'd1;
        for (int n = 0; n < 100; n++) begin
            run_decade();
            exp_carry = (exp_tens == 4'd9);
            exp_tens  = (exp_tens == 4'd9) ? 4'd0 : exp_tens + 4'd1;
            tests_run++;
            if (wrap !== 1'b1 || tens !== exp_tens || carry !== exp_carry) begin
                tests_failed++;
                $display("[TB] FAIL decade_%0d: wrap=%b tens=%0d carry=%b want wrap=1 tens=%0d carry=%b",
                         n, wrap, tens, carry, exp_tens, exp_carry);
            end
            if (exp_carry) begin
                step();
                tests_run++;
                if (carry !== 1'b0 || wrap !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL carry_one_cycle_%0d: carry=%b wrap=%b want 0 0", n, carry, wrap);
                end
            end
        end
    endtask

    task automatic test_scan_frame();
        logic [1:0] prev_an;
        logic [1:0] exp_an;
        logic [6:0] exp_seg;
        bit         found;
        run_decade();
        run_decade();
        z_in = 4'd7;
        step();
        step();
        tests_run++;
        if (tens !== 4'd3) begin
            tests_failed++;
            $display("[TB] FAIL frame_tens: tens=%0d want 3", tens);
        end
        found   = 1'b0;
        prev_an = an;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (prev_an == 2'b11 && an == 2'b10) found = 1'b1;
            else prev_an = an;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("[TB] FAIL frame_start: no ONES slot seen within 200 cycles, last an=%b", an);
        end else begin
            for (int c = 0; c < 64; c++) begin
                case (c / 16)
                    0:       begin exp_an = 2'b10; exp_seg = 7'h78; end
                    2:       begin exp_an = 2'b01; exp_seg = 7'h30; end
                    default: begin exp_an = 2'b11; exp_seg = 7'h7F; end
                endcase
                tests_run++;
                if (an !== exp_an || seg !== exp_seg) begin
                    tests_failed++;
                    $display("[TB] FAIL frame_cycle_%0d: an=%b seg=%h want an=%b seg=%h", c, an, seg, exp_an, exp_seg);
                end
                step();
            end
        end
    endtask

    task automatic test_invalid_bcd();
        bit found;
        z_in = 4'hC;
        step();
        tests_run++;
        if (bcd_err !== 1'b1 || wrap !== 1'b0 || tens !== 4'd3) begin
            tests_failed++;
            $display("[TB] FAIL invalid_flag: err=%b wrap=%b tens=%0d want err=1 wrap=0 tens=3", bcd_err, wrap, tens);
        end
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (an == 2'b10) found = 1'b1;
        end
        tests_run++;
        if (!found || seg !== 7'h7F || tens !== 4'd3) begin
            tests_failed++;
            $display("[TB] FAIL invalid_blank: found=%b an=%b seg=%h tens=%0d want an=10 seg=7f tens=3", found, an, seg, tens);
        end
        z_in = 4'd0;
        step();
        tests_run++;
        if (bcd_err !== 1'b0 || wrap !== 1'b0 || tens !== 4'd3) begin
            tests_failed++;
            $display("[TB] FAIL invalid_to_zero: err=%b wrap=%b tens=%0d want err=0 wrap=0 tens=3", bcd_err, wrap, tens);
        end
    endtask

    task automatic test_mid_scan_reset();
        bit found;
        run_decade();
        run_decade();
        z_in  = 4'd7;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (an == 2'b01) found = 1'b1;
        end
        step();
        step();
        tests_run++;
        if (!found || an !== 2'b01 || tens !== 4'd5) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_tens_slot: found=%b an=%b tens=%0d want an=01 tens=5", found, an, tens);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if (seg !== 7'h7F || an !== 2'b11 || tens !== 4'd0 || wrap !== 1'b0 || carry !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_state: seg=%h an=%b tens=%0d wrap=%b carry=%b want seg=7f an=11 tens=0 0 0",
                     seg, an, tens, wrap, carry);
        end
        for (int c = 0; c < 16; c++) begin
            step();
            tests_run++;
            if (an !== 2'b10) begin
                tests_failed++;
                $display("[TB] FAIL post_reset_ones_%0d: an=%b want 10", c, an);
            end
        end
        step();
        tests_run++;
        if (an !== 2'b11 || seg !== 7'h7F) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_blank: an=%b seg=%h want an=11 seg=7f", an, seg);
        end
    endtask

    task automatic test_leading_zero();
        logic [1:0] exp_an;
        logic [6:0] exp_seg;
`ifdef LEADING_ZERO_BLANK_EN
        exp_an  = 2'b11;
        exp_seg = 7'h7F;
`else
        exp_an  = 2'b01;
        exp_seg = 7'h40;
`endif
        z_in  = 4'd7;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 33; i++) step();
        for (int c = 0; c < 16; c++) begin
            tests_run++;
            if (an !== exp_an || seg !== exp_seg || tens !== 4'd0) begin
                tests_failed++;
                $display("[TB] FAIL tens_zero_slot_%0d: an=%b seg=%h tens=%0d want an=%b seg=%h tens=0",
                         c, an, seg, tens, exp_an, exp_seg);
            end
            step();
        end
        tests_run++;
        if (an !== 2'b11 || seg !== 7'h7F) begin
            tests_failed++;
            $display("[TB] FAIL after_tens_blank: an=%b seg=%h want an=11 seg=7f", an, seg);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        z_in         = 4'd0;
        test_reset();
        test_count_wrap();
        test_hundreds_carry();
        test_scan_frame();
        test_invalid_bcd();
        test_mid_scan_reset();
        test_leading_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
